avalon_pio_out: RTL and testbench

Avalon-MM slave output port for the CPU system: the write-side counterpart of the switch input PIO, driving board LEDs or other static outputs. Software writes a data register directly or through atomic bit-set/bit-clear addresses. An optional timed-pulse register inverts selected bits for a fixed number of clocks and then restores them. The block sits on the system interconnect beside the input PIOs and uses the same 2-bit address, 32-bit data, single-cycle slave conventions.

---
 rtl/avalon_pio_out.sv | 121 ++++++++++++
 tb/tb_avalon_pio_out.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_out.sv
// avalon_pio_out: Avalon-MM output PIO with direct, bit-set and bit-clear writes.
// Optional timed-pulse register (macro PIO_OUT_PULSE_EN) inverts selected output
// bits for PULSE_CYCLES clocks, then restores them.
// Register map: 0 data, 1 set (reads out_port), 2 clear (reads 0), 3 pulse mask.
module avalon_pio_out #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      PULSE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pulse_mask_q;
  logic [31:0]      readdata_q, readdata_d;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Bits of writedata above WIDTH-1 are deliberately ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Data register next state: direct write, atomic set, atomic clear.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        2'd0:    data_d = wdata;
        2'd1:    data_d = data_q | wdata;
        2'd2:    data_d = data_q & ~wdata;
        default: data_d = data_q;
      endcase
    end
  end

`ifdef PIO_OUT_PULSE_EN
  localparam int unsigned     CntW    = $clog2(PULSE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_CYCLES - 1);

  logic [WIDTH-1:0] pulse_mask_d;
  logic [CntW-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic             pulse_active;
  logic             pulse_expire;
  logic             pulse_wr;

  assign pulse_active = (pulse_mask_q != '0);
  assign pulse_expire = pulse_active && (pulse_cnt_q == '0);
  assign pulse_wr     = wr_en && (address == 2'd3) && (wdata != '0);

  // Pulse mask/counter: a new pulse write reloads the shared counter; if it lands
  // on the expiry edge the old bits are dropped and only the new mask remains.
  always_comb begin
    pulse_mask_d = pulse_mask_q;
    pulse_cnt_d  = pulse_cnt_q;
    if (pulse_wr) begin
      pulse_mask_d = pulse_expire ? wdata : (pulse_mask_q | wdata);
      pulse_cnt_d  = CntLoad;
    end else if (pulse_active) begin
      if (pulse_expire) begin
        pulse_mask_d = '0;
      end else begin
        pulse_cnt_d = pulse_cnt_q - CntW'(1);
      end
    end
  end

  // Pulse state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_mask_q <= '0;
      pulse_cnt_q  <= '0;
    end else begin
      pulse_mask_q <= pulse_mask_d;
      pulse_cnt_q  <= pulse_cnt_d;
    end
  end
`else
  // No pulse logic: mask is constant zero so out_port follows data_q directly.
  assign pulse_mask_q = '0;

  logic unused_pulse_cycles;
  assign unused_pulse_cycles = ^PULSE_CYCLES;
`endif

  assign out_port = data_q ^ pulse_mask_q;

  // Read mux, sampled every clock regardless of chipselect; upper bits stay zero.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_q;
      2'd1:    readdata_d[WIDTH-1:0] = out_port;
      2'd3:    readdata_d[WIDTH-1:0] = pulse_mask_q;
      default: readdata_d = '0;
    endcase
  end

  // Data and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_avalon_pio_out.sv
// tb_avalon_pio_out: directed plus random bus traffic checked against a cycle-indexed
// reference model (pulse tracked as a mask plus an absolute expiry cycle).
// Follows PIO_OUT_PULSE_EN the same way the design does.
module tb_avalon_pio_out;

  localparam int unsigned W  = 8;
  localparam logic [7:0]  RV = 8'hA5;
  localparam int unsigned PC = 4;

`ifdef PIO_OUT_PULSE_EN
  localparam bit PulseEn = 1'b1;
`else
  localparam bit PulseEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  avalon_pio_out #(
    .WIDTH       (W),
    .RESET_VALUE (RV),
    .PULSE_CYCLES(PC)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_cycle;
  int         m_expire;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = RV;
    m_mask = '0;
  endtask

  // One bus clock: drive, take the edge, advance the model, then check outputs.
  task automatic bus_cycle(input logic cs, input logic wn, input logic [1:0] a,
                           input logic [31:0] wd, input string tag);
    logic [31:0] exp_rd;
    logic [7:0]  m;
    logic [7:0]  nd;
    bit          wr;
    bit          expiring;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    wr = cs && !wn;
    m  = wd[7:0];
    case (a)
      2'd0:    exp_rd = {24'h0, m_data};
      2'd1:    exp_rd = {24'h0, m_data ^ m_mask};
      2'd3:    exp_rd = {24'h0, m_mask};
      default: exp_rd = 32'h0;
    endcase
    nd = m_data;
    if (wr && a == 2'd0) nd = m;
    if (wr && a == 2'd1) nd = m_data | m;
    if (wr && a == 2'd2) nd = m_data & ~m;
    expiring = (m_mask != 0) && (m_cycle == m_expire);
    if (PulseEn && wr && a == 2'd3 && m != 0) begin
      m_mask   = expiring ? m : (m_mask | m);
      m_expire = m_cycle + PC;
    end else if (expiring) begin
      m_mask = '0;
    end
    m_data = nd;
    m_cycle++;
    #1;
    check_eq({tag, "/out_port"}, {24'h0, out_port}, {24'h0, m_data ^ m_mask});
    check_eq({tag, "/readdata"}, readdata, exp_rd);
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input string tag);
    bus_cycle(1'b1, 1'b0, a, wd, tag);
  endtask

  task automatic rd_reg(input logic [1:0] a, input string tag);
    bus_cycle(1'b1, 1'b1, a, 32'h0, tag);
  endtask

  initial begin
    m_cycle    = 0;
    m_expire   = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    model_reset();
    #12;
    check_eq("reset/out_port", {24'h0, out_port}, {24'h0, RV});
    check_eq("reset/readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    rd_reg(2'd0, "rd_data");
    rd_reg(2'd0, "rd_data2");
    check_eq("rd_data_const", readdata, 32'h0000_00A5);

    wr_reg(2'd0, 32'hFFFF_FF3C, "wr_direct");
    check_eq("direct_const", {24'h0, out_port}, 32'h3C);
    wr_reg(2'd1, 32'h0000_0003, "wr_set");
    check_eq("set_const", {24'h0, out_port}, 32'h3F);
    wr_reg(2'd2, 32'h0000_0030, "wr_clear");
    check_eq("clear_const", {24'h0, out_port}, 32'h0F);
    rd_reg(2'd1, "rd_out");
    rd_reg(2'd2, "rd_zero");

    // Single pulse, then watch it expire.
    wr_reg(2'd3, 32'h0000_0081, "pulse");
    if (PulseEn) check_eq("pulse_const", {24'h0, out_port}, 32'h8E);
    for (int i = 0; i < 6; i++) rd_reg(2'd3, "pulse_rd");
    check_eq("pulse_done_const", {24'h0, out_port}, 32'h0F);

    // Retrigger two clocks after the first write.
    wr_reg(2'd3, 32'h1, "retrig_a");
    rd_reg(2'd3, "retrig_idle");
    wr_reg(2'd3, 32'h2, "retrig_b");
    for (int i = 0; i < 5; i++) rd_reg(2'd1, "retrig_rd");

    // Pulse write exactly on the expiry edge of an earlier pulse.
    wr_reg(2'd3, 32'h1, "exp_a");
    for (int i = 0; i < int'(PC) - 1; i++) rd_reg(2'd3, "exp_wait");
    wr_reg(2'd3, 32'h10, "exp_b");
    if (PulseEn) check_eq("exp_const", {24'h0, out_port}, 32'h1F);
    for (int i = 0; i < 5; i++) rd_reg(2'd3, "exp_rd");

    // Zero-mask pulse write and a data write during a pulse.
    wr_reg(2'd3, 32'h0, "pulse_zero");
    wr_reg(2'd3, 32'h44, "pulse_c");
    wr_reg(2'd0, 32'h5A, "data_mid_pulse");
    rd_reg(2'd1, "mid_rd");

    // Asynchronous reset in the middle of a pulse.
    wr_reg(2'd3, 32'hF0, "pulse_d");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst/out_port", {24'h0, out_port}, {24'h0, RV});
    check_eq("async_rst/readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_reg(2'd3, "post_rst_mask");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd = wd & 32'hFFFF_FF00;
      bus_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                2'($urandom_range(0, 3)), wd, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
